image_load_buffer: RTL and testbench



---
 rtl/image_load_buffer.sv | 127 ++++++++++++
 tb/tb_image_load_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/image_load_buffer.sv
// image_load_buffer: captures a row-major IMG_W x IMG_H frame, one pixel per
// accepted strobe, into a flat packed register buffer for the conv2d stage.
// loading_done is a level that stays high while a complete frame is held.
// Optional build macro IMAGE_LOAD_SYNC_STROBE_EN: passes pixel_valid and
// load_start through 2-flop synchronizers plus rising-edge detectors so the
// strobes can come from switches or pins. This adds 2 cycles of acceptance
// latency, and pixel_in must then be held stable for at least 3 clk.
module image_load_buffer #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      load_start,
  input  logic [PIX_W-1:0]                          pixel_in,
  input  logic                                      pixel_valid,
  output logic [IMG_W*IMG_H*PIX_W-1:0]              image_flat,
  output logic                                      loading_done,
  output logic                                      busy,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0]          pixel_count,
  output logic                                      overflow
);

  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int CNT_W   = $clog2(NUM_PIX + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOADING = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                     r_state;
  logic [NUM_PIX*PIX_W-1:0]   r_img;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_done;
  logic                       r_busy;
  logic                       r_ovf;

  logic                       w_pix_acc;
  logic                       w_start;

`ifdef IMAGE_LOAD_SYNC_STROBE_EN
  // [0],[1] form the synchronizer; [2] holds the previous synchronized level
  logic [2:0] r_pv_sync;
  logic [2:0] r_ls_sync;

  // Synchronize both strobes and keep one extra stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv_sync <= '0;
      r_ls_sync <= '0;
    end else begin
      r_pv_sync <= {r_pv_sync[1:0], pixel_valid};
      r_ls_sync <= {r_ls_sync[1:0], load_start};
    end
  end

  // One event per rising edge; a strobe held high counts once
  always_comb begin
    w_pix_acc = r_pv_sync[1] & ~r_pv_sync[2];
    w_start   = r_ls_sync[1] & ~r_ls_sync[2];
  end
`else
  // Strobes are level-sampled directly every cycle
  always_comb begin
    w_pix_acc = pixel_valid;
    w_start   = load_start;
  end
`endif

  // Frame-load FSM; every output is a register updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_img   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_start) begin
      // Restart wins over a coincident pixel; old contents are overwritten
      // slot by slot rather than cleared
      r_state <= S_LOADING;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_LOADING: begin
          if (w_pix_acc) begin
            for (int k = 0; k < NUM_PIX; k++) begin
              if (r_cnt == CNT_W'(k)) begin
                r_img[k*PIX_W +: PIX_W] <= pixel_in;
              end
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(NUM_PIX - 1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          // Frame is frozen for the consumer; extra strobes only flag overflow
          if (w_pix_acc) begin
            r_ovf <= 1'b1;
          end
        end
        default: begin
          // IDLE ignores pixel strobes entirely
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign image_flat   = r_img;
  assign loading_done = r_done;
  assign busy         = r_busy;
  assign pixel_count  = r_cnt;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_image_load_buffer.sv
// Testbench for image_load_buffer (default build, level-sampled strobes).
// Stimulus drives inputs on the falling edge and pushes the spec-level
// expected state after the next rising edge into a queue; a monitor pops and
// compares every output shortly after each rising edge.
module tb_image_load_buffer;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int PW = 8;
  localparam int NP = W * H;
  localparam int CW = $clog2(NP + 1);

  logic                 clk;
  logic                 rst_n;
  logic                 load_start;
  logic [PW-1:0]        pixel_in;
  logic                 pixel_valid;
  logic [NP*PW-1:0]     image_flat;
  logic                 loading_done;
  logic                 busy;
  logic [CW-1:0]        pixel_count;
  logic                 overflow;

  image_load_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .image_flat   (image_flat),
    .loading_done (loading_done),
    .busy         (busy),
    .pixel_count  (pixel_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP*PW-1:0] img;
    int               cnt;
    bit               done;
    bit               busy;
    bit               ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: frame as a byte array plus a phase (0 idle, 1 loading, 2 done)
  byte unsigned m_img[NP];
  int           m_cnt;
  int           m_phase;
  bit           m_ovf;

  task automatic chk(input string name, input logic [NP*PW-1:0] act,
                     input logic [NP*PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NP*PW-1:0] model_flat();
    logic [NP*PW-1:0] v;
    v = '0;
    for (int k = 0; k < NP; k++) v[k*PW +: PW] = m_img[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NP; k++) m_img[k] = 8'h00;
    m_cnt   = 0;
    m_phase = 0;
    m_ovf   = 1'b0;
  endtask

  // Apply one cycle of inputs and record what the outputs must be afterwards
  task automatic drive(input bit st, input bit pv, input byte unsigned pix);
    exp_t e;
    @(negedge clk);
    load_start  = st;
    pixel_valid = pv;
    pixel_in    = pix;
    if (st) begin
      m_phase = 1;
      m_cnt   = 0;
      m_ovf   = 1'b0;
    end else if (m_phase == 1 && pv) begin
      m_img[m_cnt] = pix;
      m_cnt++;
      if (m_cnt == NP) m_phase = 2;
    end else if (m_phase == 2 && pv) begin
      m_ovf = 1'b1;
    end
    e.img  = model_flat();
    e.cnt  = m_cnt;
    e.done = (m_phase == 2);
    e.busy = (m_phase == 1);
    e.ovf  = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_img"},  image_flat, '0);
    chk({tag, "_done"}, {{(NP*PW-1){1'b0}}, loading_done}, '0);
    chk({tag, "_busy"}, {{(NP*PW-1){1'b0}}, busy}, '0);
    chk({tag, "_cnt"},  {{(NP*PW-CW){1'b0}}, pixel_count}, '0);
    chk({tag, "_ovf"},  {{(NP*PW-1){1'b0}}, overflow}, '0);
  endtask

  // Monitor: compare outputs against the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("image_flat",   image_flat, e.img);
        chk("pixel_count",  {{(NP*PW-CW){1'b0}}, pixel_count}, (NP*PW)'(e.cnt));
        chk("loading_done", {{(NP*PW-1){1'b0}}, loading_done}, (NP*PW)'(e.done));
        chk("busy",         {{(NP*PW-1){1'b0}}, busy}, (NP*PW)'(e.busy));
        chk("overflow",     {{(NP*PW-1){1'b0}}, overflow}, (NP*PW)'(e.ovf));
      end
    end
  end

  initial begin
    int gap;
    rst_n       = 1'b0;
    load_start  = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Pixels in IDLE are ignored
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'hAA);
    idle(1);

    // Full frame, back-to-back
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < NP; k++) drive(1'b0, 1'b1, 8'(k));
    idle(3);

    // Overflow while DONE, then restart clears it
    drive(1'b0, 1'b1, 8'hFF);
    idle(2);
    drive(1'b1, 1'b0, 8'h00);

    // Gapped load with random pixel values
    for (int k = 0; k < NP; k++) begin
      gap = int'($urandom_range(0, 5));
      idle(gap);
      drive(1'b0, 1'b1, 8'($urandom));
    end
    idle(2);

    // Restart collision
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, 8'h11);
    drive(1'b1, 1'b1, 8'h55);
    idle(2);
    for (int k = 0; k < NP; k++) drive(1'b0, 1'b1, 8'h22);
    idle(2);

    // Async reset mid-load
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 30; k++) drive(1'b0, 1'b1, 8'($urandom));
    @(posedge clk);
    #2;
    pixel_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #1;
    rst_n = 1'b1;
    idle(2);
    drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < NP; k++) drive(1'b0, 1'b1, 8'($urandom));
    idle(3);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
